// File: rtl/imm_ext_arbiter.sv
// Round-robin shared 16->32 bit immediate extender with a one-entry valid/ready output register.
// Define IMM_EXT_SHIFT2_EN to make mode 10 produce a word-aligned (shifted left by 2) branch offset.
module imm_ext_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [15:0] req0_imm,
   input  logic [1:0]  req0_mode,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [15:0] req1_imm,
   input  logic [1:0]  req1_mode,
   output logic        req1_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_src,
   output logic [15:0] ext_count
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t      state, state_next;
   logic        last_grant;
   logic        winner;
   logic        load_en;
   logic        accept;
   logic [15:0] sel_imm;
   logic [1:0]  sel_mode;

   function automatic logic [31:0] extend(input logic [15:0] imm, input logic [1:0] mode);
      logic [31:0] sext;
      logic [31:0] res;
      sext = {{16{imm[15]}}, imm};
      res  = sext;
      case (mode)
         2'b01:   res = {16'h0000, imm};
`ifdef IMM_EXT_SHIFT2_EN
         2'b10:   res = {sext[29:0], 2'b00};
`else
         2'b10:   res = sext;
`endif
         2'b11:   res = {imm, 16'h0000};
         default: res = sext;
      endcase
      return res;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_next;
   end

   // Readies are gated by rst_n so nothing is handed out while reset is held.
   always_comb begin
      state_next = state;
      winner     = req1_valid;
      if (req0_valid && req1_valid) winner = ~last_grant;
      load_en    = rst_n && ((state == EMPTY) || out_ready);
      req0_ready = load_en && req0_valid && !winner;
      req1_ready = load_en && req1_valid && winner;
      accept     = req0_ready || req1_ready;
      sel_imm    = winner ? req1_imm  : req0_imm;
      sel_mode   = winner ? req1_mode : req0_mode;
      out_valid  = (state == FULL);
      if (accept)                          state_next = FULL;
      else if (state == FULL && out_ready) state_next = EMPTY;
   end

   // last_grant resets to 1 so requester 0 wins the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data   <= 32'h0;
         out_src    <= 1'b0;
         last_grant <= 1'b1;
      end else if (accept) begin
         out_data   <= extend(sel_imm, sel_mode);
         out_src    <= winner;
         last_grant <= winner;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                         ext_count <= 16'h0;
      else if (out_valid && out_ready && ext_count != 16'hFFFF) ext_count <= ext_count + 16'h1;
   end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Self-checking bench for imm_ext_arbiter: directed steps plus random traffic against a queue-free behavioural model.
module tb_imm_ext_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        r0v = 1'b0, r1v = 1'b0, ordy = 1'b0;
   logic [15:0] r0i = 16'h0, r1i = 16'h0;
   logic [1:0]  r0m = 2'b0, r1m = 2'b0;
   logic        req0_ready, req1_ready, out_valid, out_src;
   logic [31:0] out_data;
   logic [15:0] ext_count;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   // Behavioural model of what the consumer should observe.
   logic        mValid = 1'b0, mSrc = 1'b0, mLast = 1'b1;
   logic [31:0] mData = 32'h0;
   int          mCount = 0;
   logic        acc0, acc1;

   imm_ext_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(r0v), .req0_imm(r0i), .req0_mode(r0m), .req0_ready(req0_ready),
      .req1_valid(r1v), .req1_imm(r1i), .req1_mode(r1m), .req1_ready(req1_ready),
      .out_valid(out_valid), .out_ready(ordy), .out_data(out_data), .out_src(out_src),
      .ext_count(ext_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] refExtend(input logic [15:0] imm, input logic [1:0] mode);
      int s;
      s = (imm >= 16'h8000) ? int'(imm) - 65536 : int'(imm);
      case (mode)
         2'd1:    return 32'(int'(imm));
`ifdef IMM_EXT_SHIFT2_EN
         2'd2:    return 32'(s * 4);
`else
         2'd2:    return 32'(s);
`endif
         2'd3:    return 32'(int'(imm) * 65536);
         default: return 32'(s);
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One clock: check DUT against the model before the edge, advance the model at the edge.
   task automatic applyStimulus();
      logic w, e0, e1, consume;
      #1;
      w  = (r0v && r1v) ? ~mLast : r1v;
      e0 = (!mValid || ordy) && r0v && !w;
      e1 = (!mValid || ordy) && r1v && w;
      checkOutput("req0_ready", {31'b0, req0_ready}, {31'b0, e0});
      checkOutput("req1_ready", {31'b0, req1_ready}, {31'b0, e1});
      checkOutput("out_valid",  {31'b0, out_valid},  {31'b0, mValid});
      checkOutput("out_data",   out_data,            mData);
      checkOutput("out_src",    {31'b0, out_src},    {31'b0, mSrc});
      checkOutput("ext_count",  {16'b0, ext_count},  32'(mCount));
      @(posedge clk);
      consume = mValid && ordy;
      if (consume && mCount < 65535) mCount++;
      if (e0 || e1) begin
         mValid = 1'b1;
         mData  = w ? refExtend(r1i, r1m) : refExtend(r0i, r0m);
         mSrc   = w;
         mLast  = w;
      end else if (consume) begin
         mValid = 1'b0;
      end
      acc0 = e0;
      acc1 = e1;
      @(negedge clk);
   endtask

   logic [31:0] altData [4];

   initial begin
      // Reset state
      #2;
      checkOutput("rst_out_valid", {31'b0, out_valid}, 32'h0);
      checkOutput("rst_ext_count", {16'b0, ext_count}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single sign-extend through requester 0
      r0v = 1'b1; r0i = 16'h8001; r0m = 2'b00; ordy = 1'b1;
      #1 checkOutput("t1_ready_same_cycle", {31'b0, req0_ready}, 32'h1);
      applyStimulus();
      r0v = 1'b0;
      checkOutput("t1_data", out_data, 32'hFFFF8001);
      checkOutput("t1_src", {31'b0, out_src}, 32'h0);
      applyStimulus();
      checkOutput("t1_count", {16'b0, ext_count}, 32'h1);

      // Contention alternates; requester 0 was granted last, so requester 1 goes first
      altData[0] = 32'h7FFF0000; altData[1] = 32'h00000010;
      altData[2] = 32'h7FFF0000; altData[3] = 32'h00000010;
      r0v = 1'b1; r0i = 16'h0010; r0m = 2'b01;
      r1v = 1'b1; r1i = 16'h7FFF; r1m = 2'b11;
      for (int k = 0; k < 4; k++) begin
         applyStimulus();
         checkOutput("t2_alt_data", out_data, altData[k]);
      end
      r0v = 1'b0; r1v = 1'b0;
      applyStimulus();

      // Mode 10 on requester 1
      r1v = 1'b1; r1i = 16'hFFFF; r1m = 2'b10;
      applyStimulus();
      r1v = 1'b0;
`ifdef IMM_EXT_SHIFT2_EN
      checkOutput("t3_mode10", out_data, 32'hFFFFFFFC);
`else
      checkOutput("t3_mode10", out_data, 32'hFFFFFFFF);
`endif

      // Backpressure: output stays full, requester 0 must wait
      ordy = 1'b0; r0v = 1'b1; r0i = 16'h1234; r0m = 2'b00;
      for (int k = 0; k < 5; k++) begin
         #1 checkOutput("t4_stall_ready", {31'b0, req0_ready}, 32'h0);
         applyStimulus();
      end
      ordy = 1'b1;
      #1 checkOutput("t4_drain_ready", {31'b0, req0_ready}, 32'h1);
      applyStimulus();
      r0v = 1'b0;
      checkOutput("t4_refill_valid", {31'b0, out_valid}, 32'h1);
      checkOutput("t4_refill_data", out_data, 32'h00001234);

      // Random traffic; a requester only changes its request after acceptance
      for (int k = 0; k < 400; k++) begin
         ordy = ($urandom_range(0, 3) != 0);
         applyStimulus();
         if (!r0v || acc0) begin
            r0v = ($urandom_range(0, 9) < 6); r0i = 16'($urandom); r0m = 2'($urandom);
         end
         if (!r1v || acc1) begin
            r1v = ($urandom_range(0, 9) < 6); r1i = 16'($urandom); r1m = 2'($urandom);
         end
      end
      r0v = 1'b0; r1v = 1'b0; ordy = 1'b1;
      applyStimulus();

      // Saturation of the transfer counter
      r0v = 1'b1; r0i = 16'h0042; r0m = 2'b01;
      for (int k = 0; k < 65540; k++) applyStimulus();
      checkOutput("t5_saturate", {16'b0, ext_count}, 32'h0000FFFF);

      // Asynchronous reset while full
      r1v = 1'b1; r1i = 16'h0005; r1m = 2'b00;
      ordy = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_valid", {31'b0, out_valid}, 32'h0);
      checkOutput("t6_rst_data", out_data, 32'h0);
      checkOutput("t6_rst_count", {16'b0, ext_count}, 32'h0);
      checkOutput("t6_rst_ready0", {31'b0, req0_ready}, 32'h0);
      checkOutput("t6_rst_ready1", {31'b0, req1_ready}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      mValid = 1'b0; mData = 32'h0; mSrc = 1'b0; mCount = 0; mLast = 1'b1;
      ordy = 1'b1;
      #1 checkOutput("t6_first_grant0", {31'b0, req0_ready}, 32'h1);
      checkOutput("t6_first_grant1", {31'b0, req1_ready}, 32'h0);
      applyStimulus();
      r0v = 1'b0;
      applyStimulus();
      r1v = 1'b0;
      applyStimulus();
      applyStimulus();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
